// File: rtl/gpio_handshake_sequencer.sv
// gpio_handshake_sequencer: runs a table of GPIO wait/pulse steps
// against DUT pads and reports done, error and the failing step.
module gpio_handshake_sequencer #(
  parameter  int N_GPIO  = 11,
  parameter  int N_STEPS = 8,
  parameter  int CNT_W   = 24,
  localparam int PIN_W   = $clog2(N_GPIO),
  localparam int STEP_W  = 2 + PIN_W,
  localparam int IDX_W   = $clog2(N_STEPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [N_STEPS*STEP_W-1:0] step_tab_i,
  input  logic [CNT_W-1:0]          pulse_len_i,
  input  logic [CNT_W-1:0]          timeout_i,
  input  logic [N_GPIO-1:0]         gpio_pad_i,
  output logic [N_GPIO-1:0]         gpio_drv_o,
  output logic [N_GPIO-1:0]         gpio_oe_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [IDX_W-1:0]          step_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PULSE,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_WAIT_HI = 2'b00,
    OP_WAIT_LO = 2'b01,
    OP_PULSE   = 2'b10,
    OP_END     = 2'b11
  } op_t;

  localparam logic [PIN_W:0]    PIN_LIM  = (PIN_W+1)'(N_GPIO);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_STEPS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [N_GPIO-1:0] PIN_ONE  = N_GPIO'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic              want_lo_q, want_lo_d;
  logic [N_GPIO-1:0] oe_q, oe_d;
  logic [N_GPIO-1:0] sync1_q, sync2_q;

  logic [STEP_W-1:0] tab [N_STEPS];

  for (genvar k = 0; k < N_STEPS; k++) begin : g_tab
    assign tab[k] = step_tab_i[k*STEP_W +: STEP_W];
  end

  logic [STEP_W-1:0] entry;
  op_t               ent_op;
  logic [PIN_W-1:0]  ent_pin;
  logic              ent_end;
  logic              ent_pulse;
  logic [CNT_W-1:0]  plen_eff;
  logic              pad_lvl;
  logic              wait_met;
  logic              wait_tmo;
  logic              pulse_last;
  logic              adv;

  always_comb begin
    entry      = tab[idx_q];
    ent_op     = op_t'(entry[STEP_W-1 -: 2]);
    ent_pin    = entry[PIN_W-1:0];
    // out-of-range pins terminate the table like an END entry
    ent_end    = (ent_op == OP_END) ||
                 ({1'b0, ent_pin} >= PIN_LIM);
    ent_pulse  = !ent_end && (ent_op == OP_PULSE);
    plen_eff   = (pulse_len_i == '0) ? CNT_ONE
                                     : pulse_len_i;
    pad_lvl    = sync2_q[pin_q];
    wait_met   = want_lo_q ? ~pad_lvl : pad_lvl;
    wait_tmo   = (timeout_i != '0) &&
                 (tcnt_q == timeout_i - CNT_ONE);
    pulse_last = (pcnt_q <= CNT_ONE);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    pcnt_d    = pcnt_q;
    pin_d     = pin_q;
    want_lo_d = want_lo_q;
    oe_d      = '0;
    adv       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        pin_d     = ent_pin;
        want_lo_d = (ent_op == OP_WAIT_LO);
        unique case (1'b1)
          ent_end: begin
            state_d = S_DONE;
          end
          ent_pulse: begin
            state_d = S_PULSE;
            pcnt_d  = plen_eff;
            oe_d    = PIN_ONE << ent_pin;
          end
          default: begin
            state_d = S_WAIT;
            tcnt_d  = '0;
          end
        endcase
      end
      S_WAIT: begin
        if (wait_met) begin
          adv = 1'b1;
        end else begin
          if (tcnt_q != CNT_MAX) begin
            tcnt_d = tcnt_q + CNT_ONE;
          end
          if (wait_tmo) begin
            state_d = S_ERR;
          end
        end
      end
      S_PULSE: begin
        if (pulse_last) begin
          adv = 1'b1;
        end else begin
          pcnt_d = pcnt_q - CNT_ONE;
          oe_d   = oe_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + IDX_ONE;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tcnt_q    <= '0;
      pcnt_q    <= '0;
      pin_q     <= '0;
      want_lo_q <= 1'b0;
      oe_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      pin_q     <= pin_d;
      want_lo_q <= want_lo_d;
      oe_q      <= oe_d;
      sync1_q   <= gpio_pad_i;
      sync2_q   <= sync1_q;
    end
  end

  assign gpio_oe_o  = oe_q;
  assign gpio_drv_o = oe_q;
  assign busy_o     = (state_q == S_FETCH) ||
                      (state_q == S_WAIT)  ||
                      (state_q == S_PULSE);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERR);
  assign step_idx_o = idx_q;

endmodule

// File: tb/tb_gpio_handshake_sequencer.sv
// tb_gpio_handshake_sequencer: directed and randomized checks of the
// GPIO handshake sequencer against a step-timeline reference model.
module tb_gpio_handshake_sequencer;

  localparam int NG   = 11;
  localparam int NS   = 8;
  localparam int CW   = 24;
  localparam int PW   = 4;
  localparam int SW   = 6;
  localparam int IW   = 3;
  localparam int MAXC = 160;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [NS*SW-1:0]  step_tab_i = '1;
  logic [CW-1:0]     pulse_len_i = '0;
  logic [CW-1:0]     timeout_i = '0;
  logic [NG-1:0]     gpio_pad_i = '0;
  logic [NG-1:0]     gpio_drv_o;
  logic [NG-1:0]     gpio_oe_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic [IW-1:0]     step_idx_o;

  always #5 clk = ~clk;

  gpio_handshake_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .step_tab_i (step_tab_i),
    .pulse_len_i(pulse_len_i),
    .timeout_i  (timeout_i),
    .gpio_pad_i (gpio_pad_i),
    .gpio_drv_o (gpio_drv_o),
    .gpio_oe_o  (gpio_oe_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .step_idx_o (step_idx_o)
  );

  int checks = 0;
  int errors = 0;

  logic [NG-1:0] wave [MAXC];
  logic [SW-1:0] tab [NS];
  int            plen;
  int            tout;

  logic [NG-1:0] o_oe [MAXC];
  logic [NG-1:0] o_drv [MAXC];
  logic          o_busy [MAXC];
  logic          o_done [MAXC];
  logic          o_err [MAXC];
  logic [IW-1:0] o_idx [MAXC];

  logic [NG-1:0] m_oe [MAXC];
  logic          m_busy [MAXC];
  logic          m_done [MAXC];
  logic          m_err [MAXC];
  logic [IW-1:0] m_idx [MAXC];

  function automatic logic [SW-1:0] ent(input logic [1:0] op,
                                        input int pin);
    return {op, PW'(pin)};
  endfunction

  // Reset, then run MAXC cycles; start strobed in cycle 2
  // (first FETCH in cycle 3). Pads in cycle c come from wave[c].
  task automatic run_seq(input int extra);
    for (int k = 0; k < NS; k++) step_tab_i[k*SW +: SW] = tab[k];
    pulse_len_i = CW'(plen);
    timeout_i   = CW'(tout);
    start_i     = 1'b0;
    gpio_pad_i  = wave[0];
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      if (i > 0) @(negedge clk);
      gpio_pad_i = wave[i];
      start_i    = (i == 2) || (i == extra);
      o_oe[i]    = gpio_oe_o;
      o_drv[i]   = gpio_drv_o;
      o_busy[i]  = busy_o;
      o_done[i]  = done_o;
      o_err[i]   = error_o;
      o_idx[i]   = step_idx_o;
    end
    start_i = 1'b0;
  endtask

  task automatic mark(input int c, input int s);
    if (c < MAXC) begin
      m_busy[c] = 1'b1;
      m_idx[c]  = IW'(s);
    end
  endtask

  // Step timeline: FETCH at t, WAIT checks pads delayed by two
  // cycles, a pulse occupies t+1..t+L, the next step follows.
  task automatic model();
    int t, s, nxt, fin_c, pin, lim, c;
    bit fin, ok;
    logic [1:0] op;
    for (int i = 0; i < MAXC; i++) begin
      m_oe[i] = '0; m_busy[i] = 0; m_done[i] = 0;
      m_err[i] = 0; m_idx[i] = '0;
    end
    t = 3; s = 0; fin = 0; ok = 0; fin_c = MAXC;
    while (!fin && t < MAXC) begin
      op  = tab[s][5:4];
      pin = int'(tab[s][3:0]);
      mark(t, s);
      nxt = MAXC;
      if (op == 2'b11 || pin >= NG) begin
        fin = 1; ok = 1; fin_c = t + 1;
      end else if (op == 2'b10) begin
        lim = (plen == 0) ? 1 : plen;
        for (int d = 1; d <= lim; d++) begin
          mark(t + d, s);
          if (t + d < MAXC) m_oe[t+d] = NG'(1) << pin;
        end
        nxt = t + lim + 1;
      end else begin
        for (int kk = 0; t + 1 + kk < MAXC; kk++) begin
          c = t + 1 + kk;
          mark(c, s);
          if (wave[c-2][pin] == (op == 2'b00)) begin
            nxt = c + 1;
            break;
          end
          if (tout != 0 && kk == tout - 1) begin
            fin = 1; ok = 0; fin_c = c + 1;
            break;
          end
        end
      end
      if (!fin) begin
        if (s == NS - 1) begin
          fin = 1; ok = 1; fin_c = nxt;
        end else begin
          s++;
          t = nxt;
        end
      end
    end
    if (fin) begin
      for (int i = fin_c; i < MAXC; i++) begin
        m_done[i] = ok;
        m_err[i]  = !ok;
        m_idx[i]  = IW'(s);
      end
    end
  endtask

  function automatic int first_done();
    for (int i = 0; i < MAXC; i++) if (o_done[i]) return i;
    return -1;
  endfunction

  function automatic int first_err();
    for (int i = 0; i < MAXC; i++) if (o_err[i]) return i;
    return -1;
  endfunction

  function automatic int first_oe(input int b);
    for (int i = 0; i < MAXC; i++) if (o_oe[i][b]) return i;
    return -1;
  endfunction

  function automatic int oe_cycles(input int b);
    int n = 0;
    for (int i = 0; i < MAXC; i++) if (o_oe[i][b]) n++;
    return n;
  endfunction

  function automatic int stray(input logic [NG-1:0] mask);
    int n = 0;
    for (int i = 0; i < MAXC; i++)
      if ((o_oe[i] & ~mask) != '0 || o_drv[i] != o_oe[i]) n++;
    return n;
  endfunction

  task automatic fill_end();
    for (int k = 0; k < NS; k++) tab[k] = ent(2'b11, 0);
  endtask

  task automatic test_reset();
    logic [NG-1:0] p4;
    p4 = NG'(1) << 4;
    rst = 1'b1; start_i = 1'b0; gpio_pad_i = '0;
    step_tab_i = '1;
    step_tab_i[0 +: SW] = ent(2'b10, 4);
    pulse_len_i = CW'(20); timeout_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, error_o, step_idx_o, gpio_oe_o, gpio_drv_o} !== '0)
      begin errors++; $display("FAIL reset_state got %b %b %b %0d %h %h want all 0",
        busy_o, done_o, error_o, step_idx_o, gpio_oe_o, gpio_drv_o); end
    rst = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (gpio_oe_o !== p4 || gpio_drv_o !== p4 || busy_o !== 1'b1)
      begin errors++; $display("FAIL mid_pulse got oe=%h drv=%h busy=%b want oe=drv=%h busy=1",
        gpio_oe_o, gpio_drv_o, busy_o, p4); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, error_o, gpio_oe_o, gpio_drv_o} !== '0)
      begin errors++; $display("FAIL rst_abort got busy=%b done=%b err=%b oe=%h drv=%h want 0",
        busy_o, done_o, error_o, gpio_oe_o, gpio_drv_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, error_o, gpio_oe_o} !== '0)
      begin errors++; $display("FAIL rst_idle got busy=%b done=%b err=%b oe=%h want 0",
        busy_o, done_o, error_o, gpio_oe_o); end
  endtask

  task automatic test_handshake();
    fill_end();
    tab[0] = ent(2'b00, 0);
    tab[1] = ent(2'b10, 4);
    tab[2] = ent(2'b00, 1);
    plen = 5; tout = 0;
    for (int i = 0; i < MAXC; i++) wave[i] = NG'(2) | NG'(i >= 10);
    run_seq(-1);
    checks++;
    if (first_oe(4) != 14) begin errors++;
      $display("FAIL hs_pulse_start got %0d want 14", first_oe(4)); end
    checks++;
    if (oe_cycles(4) != 5) begin errors++;
      $display("FAIL hs_pulse_len got %0d want 5", oe_cycles(4)); end
    checks++;
    if (stray(NG'(1) << 4) != 0) begin errors++;
      $display("FAIL hs_stray_drive got %0d cycles want 0", stray(NG'(1) << 4)); end
    checks++;
    if (first_done() != 22 || o_err[MAXC-1] !== 1'b0 || o_idx[MAXC-1] !== 3'd3)
      begin errors++; $display("FAIL hs_done got cyc=%0d err=%b idx=%0d want 22 0 3",
        first_done(), o_err[MAXC-1], o_idx[MAXC-1]); end
  endtask

  task automatic test_timeout();
    fill_end();
    tab[0] = ent(2'b01, 8);
    plen = 0; tout = 100;
    for (int i = 0; i < MAXC; i++) wave[i] = NG'($urandom) | (NG'(1) << 8);
    run_seq(-1);
    checks++;
    if (first_err() != 104) begin errors++;
      $display("FAIL to_err_cycle got %0d want 104", first_err()); end
    checks++;
    if (o_idx[MAXC-1] !== 3'd0 || o_busy[MAXC-1] !== 1'b0 || o_done[MAXC-1] !== 1'b0)
      begin errors++; $display("FAIL to_state got idx=%0d busy=%b done=%b want 0 0 0",
        o_idx[MAXC-1], o_busy[MAXC-1], o_done[MAXC-1]); end
    checks++;
    if (stray('0) != 0) begin errors++;
      $display("FAIL to_no_drive got %0d cycles want 0", stray('0)); end
  endtask

  task automatic test_race();
    fill_end();
    tab[0] = ent(2'b00, 2);
    tab[1] = ent(2'b10, 5);
    plen = 0; tout = 10;
    for (int i = 0; i < MAXC; i++) wave[i] = (i >= 11) ? NG'(4) : '0;
    run_seq(-1);
    checks++;
    if (first_err() != -1 || first_done() != 17)
      begin errors++; $display("FAIL race_win got err=%0d done=%0d want -1 17",
        first_err(), first_done()); end
    checks++;
    if (oe_cycles(5) != 1 || first_oe(5) != 15) begin errors++;
      $display("FAIL zero_len_pulse got n=%0d at %0d want 1 at 15",
        oe_cycles(5), first_oe(5)); end
    for (int i = 0; i < MAXC; i++) wave[i] = (i >= 12) ? NG'(4) : '0;
    run_seq(-1);
    checks++;
    if (first_err() != 14 || o_idx[MAXC-1] !== 3'd0)
      begin errors++; $display("FAIL race_late got err=%0d idx=%0d want 14 0",
        first_err(), o_idx[MAXC-1]); end
  endtask

  task automatic test_full_table();
    logic [NG-1:0] p;
    p = NG'($urandom);
    for (int k = 0; k < NS; k++) tab[k] = ent(p[k] ? 2'b00 : 2'b01, k);
    plen = 3; tout = 5;
    for (int i = 0; i < MAXC; i++) wave[i] = p;
    run_seq(-1);
    checks++;
    if (first_done() != 19 || o_busy[18] !== 1'b1)
      begin errors++; $display("FAIL full_done got cyc=%0d busy18=%b want 19 1",
        first_done(), o_busy[18]); end
    checks++;
    if (o_idx[MAXC-1] !== 3'd7 || o_err[MAXC-1] !== 1'b0)
      begin errors++; $display("FAIL full_idx got idx=%0d err=%b want 7 0",
        o_idx[MAXC-1], o_err[MAXC-1]); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NS; k++) tab[k] = ent(2'b10, 1);
    tab[0] = ent(2'b00, 3);
    tab[1] = ent(2'b10, 6);
    tab[2] = ent(2'b00, 3);
    tab[3] = ent(2'b00, 12);
    plen = 4; tout = 0;
    for (int i = 0; i < MAXC; i++) wave[i] = NG'(8);
    run_seq(7);
    checks++;
    if (oe_cycles(6) != 4 || first_oe(6) != 6) begin errors++;
      $display("FAIL busy_start_pulse got n=%0d at %0d want 4 at 6",
        oe_cycles(6), first_oe(6)); end
    checks++;
    if (first_done() != 13 || o_idx[MAXC-1] !== 3'd3)
      begin errors++; $display("FAIL bad_pin_end got cyc=%0d idx=%0d want 13 3",
        first_done(), o_idx[MAXC-1]); end
    checks++;
    if (stray(NG'(1) << 6) != 0) begin errors++;
      $display("FAIL bad_pin_drive got %0d cycles want 0", stray(NG'(1) << 6)); end
  endtask

  task automatic test_random();
    logic [NG-1:0] flip;
    logic [27:0] act, exp;
    int r;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NS; k++) begin
        r = $urandom_range(0, 9);
        tab[k] = ent(r < 4 ? 2'b00 : r < 7 ? 2'b01 : r < 9 ? 2'b10 : 2'b11,
                     $urandom_range(0, 12));
      end
      plen = $urandom_range(0, 6);
      tout = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      wave[0] = NG'($urandom);
      for (int i = 1; i < MAXC; i++) begin
        flip = '0;
        for (int b = 0; b < NG; b++) flip[b] = ($urandom_range(0, 5) == 0);
        wave[i] = wave[i-1] ^ flip;
      end
      run_seq(-1);
      model();
      for (int c = 0; c < MAXC; c++) begin
        act = {o_busy[c], o_done[c], o_err[c], o_idx[c], o_oe[c], o_drv[c]};
        exp = {m_busy[c], m_done[c], m_err[c], m_idx[c], m_oe[c], m_oe[c]};
        checks++;
        if (act !== exp) begin errors++;
          $display("FAIL rand_trace run %0d cyc %0d got %h want %h", n, c, act, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_timeout();
    test_race();
    test_full_table();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
